// File: rtl/systolic_feed_ctrl.sv
// Purpose : sequences one systolic tile pass: clear, stream K operand beats, zero-fill drain, settle, capture.
// Latency : done/out_valid K+N_SIZE+PIPE_LAT+1 cycles after the accepted start (plus one per stalled beat); k_len=0 -> 1 cycle.
// Backpr. : STREAM pops only while src_valid=1 and holds otherwise; drain/settle run unconditionally; start ignored while busy.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, k_len        - pass command and its beat count (taken only in IDLE)
//   abort               - synchronous cancel, highest priority, returns to IDLE without done
//   src_valid / src_pop - operand source handshake; rd_addr is the beat index being offered
//   skew_valid          - skew buffer valid_in; zero_fill selects zeros into the skew datapath
//   acc_clear           - one-cycle accumulator clear at the start of a pass
//   busy, out_valid, done - status; out_valid and done are coincident one-cycle strobes
//   stall_cycles        - starved STREAM cycle count, present only when FEED_CTRL_PERF_EN is defined
//
// Optional feature macro: FEED_CTRL_PERF_EN (stall performance counter; tied to 0 when undefined).

module systolic_feed_ctrl #(
  parameter int N_SIZE   = 32,
  parameter int CNT_W    = 10,
  parameter int PIPE_LAT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] k_len,
  input  logic             abort,
  input  logic             src_valid,
  output logic             src_pop,
  output logic [CNT_W-1:0] rd_addr,
  output logic             skew_valid,
  output logic             zero_fill,
  output logic             acc_clear,
  output logic             busy,
  output logic             out_valid,
  output logic             done,
  output logic [31:0]      stall_cycles
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // A 1x1 array has nothing to drain; the stream goes straight to settle.
  localparam bit HAS_DRAIN = (N_SIZE > 1);

  // Terminal values of the shared phase timer for DRAIN and SETTLE.
  // The timer restarts at 0 on every state change, so a phase of length L
  // ends when the timer reads L-1.
  localparam logic [31:0] DRAIN_LAST  = HAS_DRAIN ? 32'(N_SIZE - 2) : 32'd0;
  localparam logic [31:0] SETTLE_LAST = (PIPE_LAT > 0) ? 32'(PIPE_LAT - 1) : 32'd0;

  localparam logic [CNT_W-1:0] BEAT_ONE = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] beat_q;    // beats popped so far in this pass
  logic [CNT_W-1:0] klen_q;    // beat count latched from the accepted start
  logic [31:0]      phase_q;   // cycles spent in the current DRAIN/SETTLE phase

  // ---------------------------------------------------------------------------
  // Decodes
  // ---------------------------------------------------------------------------
  logic start_acc;   // start taken this cycle (IDLE, no abort)
  logic in_stream;
  logic in_drain;
  logic last_pop;    // the pop that completes the K beats

  assign start_acc = (state_q == S_IDLE) && start && !abort;
  assign in_stream = (state_q == S_STREAM);
  assign in_drain  = (state_q == S_DRAIN);

  // beat_q never exceeds k_len-1 while streaming, so beat_q+1 cannot wrap
  // before it matches klen_q even at the maximum k_len.
  assign last_pop  = src_pop && ((beat_q + BEAT_ONE) == klen_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          // A zero-length pass skips the clear and the stream entirely.
          state_d = (k_len == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (last_pop) begin
          state_d = HAS_DRAIN ? S_DRAIN : S_SETTLE;
        end
      end
      S_DRAIN: begin
        if (phase_q == DRAIN_LAST) begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (phase_q == SETTLE_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every transition, including a start seen in IDLE.
    if (abort) begin
      state_d = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Phase timer: zero on entry to any state, held at zero while idle so it
  // does not free-run between passes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else if ((state_d != state_q) || (state_q == S_IDLE)) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + 32'd1;
    end
  end

  // Beat counter doubles as the operand read address.  It is left at k_len
  // after the pass so rd_addr stays stable until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      klen_q <= '0;
    end else if (start_acc && (k_len != '0)) begin
      beat_q <= '0;
      klen_q <= k_len;
    end else if (src_pop) begin
      beat_q <= beat_q + BEAT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Handshake outputs are combinational so a pop can follow src_valid in the
  // same cycle; abort kills them immediately so nothing enters the skew
  // buffer in the cancelled cycle.
  assign src_pop    = in_stream && src_valid && !abort;
  assign skew_valid = src_pop || (in_drain && !abort);
  assign zero_fill  = in_drain;

  // Status outputs come from registered state only.
  assign rd_addr    = beat_q;
  assign acc_clear  = (state_q == S_CLEAR);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign done       = (state_q == S_DONE);

  // ---------------------------------------------------------------------------
  // Stall performance counter
  // ---------------------------------------------------------------------------
`ifdef FEED_CTRL_PERF_EN
  logic [31:0] stall_q;

  // Counts every STREAM cycle where the source had nothing to offer.  It is
  // only touched by an accepted start or a starved STREAM cycle, so it holds
  // its value after done or abort until the next pass begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (in_stream && !src_valid && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
module tb_systolic_feed_ctrl;

  localparam int N   = 4;
  localparam int PL  = 3;
  localparam int CW  = 10;
  localparam int MAXC = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] k_len;
  logic          abort;
  logic          src_valid;
  logic          src_pop;
  logic [CW-1:0] rd_addr;
  logic          skew_valid;
  logic          zero_fill;
  logic          acc_clear;
  logic          busy;
  logic          out_valid;
  logic          done;
  logic [31:0]   stall_cycles;

  int ncmp = 0;
  int nerr = 0;

  // Per-cycle stimulus pattern and expected schedule, indexed by cycle
  // number counted from the edge that accepts the start.
  bit          sv_pat  [0:MAXC-1];
  bit          e_busy  [0:MAXC-1];
  bit          e_clr   [0:MAXC-1];
  bit          e_pop   [0:MAXC-1];
  bit          e_skew  [0:MAXC-1];
  bit          e_zf    [0:MAXC-1];
  bit          e_done  [0:MAXC-1];
  bit          e_achk  [0:MAXC-1];
  logic [CW-1:0] e_addr [0:MAXC-1];

  systolic_feed_ctrl #(.N_SIZE(N), .CNT_W(CW), .PIPE_LAT(PL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .k_len        (k_len),
    .abort        (abort),
    .src_valid    (src_valid),
    .src_pop      (src_pop),
    .rd_addr      (rd_addr),
    .skew_valid   (skew_valid),
    .zero_fill    (zero_fill),
    .acc_clear    (acc_clear),
    .busy         (busy),
    .out_valid    (out_valid),
    .done         (done),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"},       32'(busy),       32'd0);
    chk({tag, " acc_clear"},  32'(acc_clear),  32'd0);
    chk({tag, " src_pop"},    32'(src_pop),    32'd0);
    chk({tag, " skew_valid"}, 32'(skew_valid), 32'd0);
    chk({tag, " zero_fill"},  32'(zero_fill),  32'd0);
    chk({tag, " done"},       32'(done),       32'd0);
    chk({tag, " out_valid"},  32'(out_valid),  32'd0);
    chk({tag, " rd_addr"},    32'(rd_addr),    32'd0);
    chk({tag, " stall"},      stall_cycles,    32'd0);
  endtask

  // pct = probability (percent) that the source is valid in a given cycle.
  task automatic fill_pat(input int pct);
    for (int i = 0; i < MAXC; i++) begin
      sv_pat[i] = (i >= 400) ? 1'b1 : ($urandom_range(0, 99) < pct);
    end
  endtask

  // One pass.  abort_mode: 0 none, 1 abort in the 2nd DRAIN cycle,
  // 2 abort at a random cycle between the first DRAIN cycle and the one
  // before done.  Randomly asserts start (with junk k_len) while busy.
  task automatic do_pass(input int k, input int abort_mode, input string name);
    int t;
    int pops;
    int stalls;
    int last;
    int drain_start;
    int abort_cyc;
    int lc;
    int start_lim;
    logic [31:0] exp_stall;

    for (int i = 0; i < MAXC; i++) begin
      e_busy[i] = 0; e_clr[i] = 0; e_pop[i] = 0; e_skew[i] = 0;
      e_zf[i] = 0; e_done[i] = 0; e_achk[i] = 0; e_addr[i] = '0;
    end
    stalls = 0;
    abort_cyc = 0;

    if (k == 0) begin
      last = 1;
      e_busy[1] = 1;
      e_done[1] = 1;
      drain_start = 1;
    end else begin
      e_busy[1] = 1; e_clr[1] = 1; e_achk[1] = 1; e_addr[1] = '0;
      t = 2;
      pops = 0;
      while (pops < k) begin
        e_busy[t] = 1; e_achk[t] = 1; e_addr[t] = CW'(pops);
        if (sv_pat[t]) begin
          e_pop[t] = 1; e_skew[t] = 1; pops++;
        end else begin
          stalls++;
        end
        t++;
      end
      drain_start = t;
      for (int d = 0; d < N - 1; d++) begin
        e_busy[t] = 1; e_zf[t] = 1; e_skew[t] = 1; t++;
      end
      for (int s = 0; s < PL; s++) begin
        e_busy[t] = 1; t++;
      end
      e_busy[t] = 1; e_done[t] = 1;
      last = t;
      if (abort_mode == 1) abort_cyc = drain_start + 1;
      if (abort_mode == 2) abort_cyc = $urandom_range(drain_start, last - 1);
    end

    if (abort_cyc > 0) begin
      e_skew[abort_cyc] = 0;
      e_pop[abort_cyc]  = 0;
      for (int i = abort_cyc + 1; i < MAXC; i++) begin
        e_busy[i] = 0; e_clr[i] = 0; e_pop[i] = 0; e_skew[i] = 0;
        e_zf[i] = 0; e_done[i] = 0; e_achk[i] = 0;
      end
      lc = abort_cyc + 1;
      start_lim = abort_cyc;
    end else begin
      lc = last;
      start_lim = last;
    end

`ifdef FEED_CTRL_PERF_EN
    exp_stall = 32'(stalls);
`else
    exp_stall = 32'd0;
`endif

    start = 1'b1;
    k_len = CW'(k);
    abort = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 1; c <= lc; c++) begin
      start     = (c <= start_lim) ? ($urandom_range(0, 3) == 0) : 1'b0;
      k_len     = CW'($urandom);
      src_valid = sv_pat[c];
      abort     = (c == abort_cyc);
      @(negedge clk);
      chk($sformatf("%s c%0d busy", name, c),       32'(busy),       32'(e_busy[c]));
      chk($sformatf("%s c%0d acc_clear", name, c),  32'(acc_clear),  32'(e_clr[c]));
      chk($sformatf("%s c%0d src_pop", name, c),    32'(src_pop),    32'(e_pop[c]));
      chk($sformatf("%s c%0d skew_valid", name, c), 32'(skew_valid), 32'(e_skew[c]));
      chk($sformatf("%s c%0d zero_fill", name, c),  32'(zero_fill),  32'(e_zf[c]));
      chk($sformatf("%s c%0d done", name, c),       32'(done),       32'(e_done[c]));
      chk($sformatf("%s c%0d out_valid", name, c),  32'(out_valid),  32'(e_done[c]));
      if (e_achk[c]) begin
        chk($sformatf("%s c%0d rd_addr", name, c), 32'(rd_addr), 32'(e_addr[c]));
      end
      @(posedge clk);
      #1;
    end
    start     = 1'b0;
    abort     = 1'b0;
    src_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("%s idle busy", name),  32'(busy), 32'd0);
    chk($sformatf("%s idle done", name),  32'(done), 32'd0);
    chk($sformatf("%s stall_cycles", name), stall_cycles, exp_stall);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; k_len = '0; abort = 1'b0; src_valid = 1'b0;
    #12;
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    // Reset in the middle of STREAM, then a clean k_len=2 pass.
    start = 1'b1; k_len = CW'(3);
    @(posedge clk);
    #1 start = 1'b0; src_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk);
    #1 rst_n = 1'b1; src_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all_zero($sformatf("after_reset%0d", i));
    end
    fill_pat(100);
    do_pass(2, 0, "k2_after_reset");

    // Nominal k_len=5 pass with source always valid (done in cycle 13).
    do_pass(5, 0, "k5_full");

    // Three stalled cycles mid-stream (done in cycle 16, stall count 3).
    fill_pat(100);
    sv_pat[4] = 0; sv_pat[5] = 0; sv_pat[6] = 0;
    do_pass(5, 0, "k5_stall3");

    // Zero-length pass, then immediately another pass back to back.
    fill_pat(100);
    do_pass(0, 0, "k0");
    do_pass(3, 0, "b2b");

    // Abort in the second drain cycle, with stray starts during the pass.
    fill_pat(60);
    do_pass(5, 1, "abort_drain2");

    // Abort together with start in IDLE: start must be dropped.
    start = 1'b1; abort = 1'b1; k_len = CW'(4);
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_start busy", 32'(busy), 32'd0);
    chk("abort_start acc_clear", 32'(acc_clear), 32'd0);
    @(negedge clk);
    chk("abort_start busy2", 32'(busy), 32'd0);

    // Randomized passes, some aborted late in the pass.
    for (int p = 0; p < 16; p++) begin
      fill_pat($urandom_range(40, 100));
      do_pass($urandom_range(0, 20), ($urandom_range(0, 2) == 0) ? 2 : 0,
              $sformatf("rnd%0d", p));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
